dmem_bridge: RTL and testbench

- Sits directly downstream of the MEM-stage byte-select logic and connects the core's data-memory port to an external handshake data bus (req / addr_ok / data_ok).
- Shifts the low-lane-aligned write enables and write data onto the lanes selected by address bits [1:0], and right-justifies returned read data so load extension sees the addressed byte or halfword in bits [7:0] / [15:0].
- Owns the MEM-stage memory stall.

---
 rtl/dmem_bridge.sv | 152 +++++++++++++++
 tb/tb_dmem_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the MEM-stage data-memory port to a req/addr_ok/data_ok bus.
//   - Shifts low-lane-aligned byte enables and store data onto the lanes chosen by
//     addrM[1:0], and right-justifies returned load data (zero-filled) into readdata.
//   - Owns the MEM-stage stall: stall_mem holds the pipeline until the load data
//     is registered (or the store completes).
//   - A flush during an outstanding transaction lets the bus finish, then drops
//     the result and returns to IDLE without presenting a HOLD cycle.
// Optional build macro: WRITE_POST_EN -- stores release the stall on addr_ok and
//   complete in the background (one posted write at most); the next request waits
//   in IDLE until the posted write's data_ok.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_en, wea, addrM,       MEM-stage access (wea==0 means load)
//   writedataM, flush,
//   mem_advance
//   readdata, stall_mem       right-justified load data, pipeline hold
//   data_req .. data_wdata    bus request channel
//   data_addr_ok, data_data_ok, data_rdata   bus responses
module dmem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        wea,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              flush,
    input  logic              mem_advance,
    output logic [DATA_W-1:0] readdata,
    output logic              stall_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t      state, stateNext;
    logic        cancel;
    logic        cancelEff;
    logic        issue;
    logic        respDone;
    logic [1:0]  laneOff;
    logic [3:0]  wstrbShift;
    logic [DATA_W-1:0] wdataShift;

    assign wstrbShift = wea << addrM[1:0];
    assign wdataShift = writedataM << {addrM[1:0], 3'b000};

    // A flush arriving in the same cycle as data_ok must already drop the result.
    assign cancelEff = cancel | flush;

`ifdef WRITE_POST_EN
    logic wrPend;

    // Set when a store is accepted without its completion; cleared by that data_ok.
    always_ff @(posedge clk) begin
        if (rst)
            wrPend <= 1'b0;
        else if (state == REQ && data_addr_ok && !data_data_ok && data_wr)
            wrPend <= 1'b1;
        else if (data_data_ok)
            wrPend <= 1'b0;
    end
`endif

    always_comb begin
        stateNext = state;
        stall_mem = 1'b0;
        data_req  = 1'b0;
        issue     = 1'b0;
        respDone  = 1'b0;
        case (state)
            IDLE: begin
                stall_mem = mem_en & ~flush;
                if (mem_en && !flush) begin
                    issue     = 1'b1;
                    stateNext = REQ;
`ifdef WRITE_POST_EN
                    // Fields are re-latched each cycle while waiting; that is harmless
                    // because the stalled pipeline holds them steady.
                    if (wrPend && !data_data_ok)
                        stateNext = IDLE;
`endif
                end
            end
            REQ: begin
                data_req  = 1'b1;
                stall_mem = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    respDone  = 1'b1;
                    stateNext = cancelEff ? IDLE : HOLD;
                end else if (data_addr_ok) begin
`ifdef WRITE_POST_EN
                    stateNext = data_wr ? (cancelEff ? IDLE : HOLD) : RESP;
`else
                    stateNext = RESP;
`endif
                end
            end
            RESP: begin
                stall_mem = 1'b1;
                if (data_data_ok) begin
                    respDone  = 1'b1;
                    stateNext = cancelEff ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (mem_advance)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            readdata   <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wr    <= 1'b0;
            data_wstrb <= 4'b0000;
            laneOff    <= 2'b00;
        end else begin
            state <= stateNext;
            if (issue) begin
                data_addr  <= {addrM[ADDR_W-1:2], 2'b00};
                data_wstrb <= wstrbShift;
                data_wdata <= wdataShift;
                data_wr    <= |wea;
                laneOff    <= addrM[1:0];
            end
            // Stores and cancelled loads leave readdata untouched.
            if (respDone && !data_wr && !cancelEff)
                readdata <= data_rdata >> {laneOff, 3'b000};
            if (stateNext == IDLE)
                cancel <= 1'b0;
            else if (flush && (state == REQ || state == RESP))
                cancel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: the driver pushes the expected bus request and
// the expected completion (readdata, stall length) into queues; the monitor pops
// and compares when the DUT presents a bus handshake or releases the stall.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  wea;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic        flush;
    logic        mem_advance;
    logic [31:0] readdata;
    logic        stall_mem;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .wea(wea), .addrM(addrM),
        .writedataM(writedataM), .flush(flush), .mem_advance(mem_advance),
        .readdata(readdata), .stall_mem(stall_mem), .data_req(data_req),
        .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WRITE_POST_EN
    localparam int ST_STALL  = 2;
    localparam int SW_SLOW   = 2;
    localparam int LW_BEHIND = 5;
`else
    localparam int ST_STALL  = 3;
    localparam int SW_SLOW   = 6;
    localparam int LW_BEHIND = 3;
`endif

    typedef struct { logic wr; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata; } reqExp_t;
    typedef struct { logic [31:0] rd; int stall; } cmpExp_t;

    reqExp_t reqQ[$];
    cmpExp_t cmpQ[$];
    int nChk = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus model: addr_ok after aokDly waiting cycles, data_ok dokDly cycles later.
    int aokDly, dokDly, aCnt, dCnt;
    bit waitData;
    logic [31:0] busRdata;

    initial begin
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        waitData = 0; aCnt = 0; dCnt = 0;
        forever begin
            @(posedge clk); #2;
            data_addr_ok = 0; data_data_ok = 0;
            if (rst) begin
                waitData = 0; aCnt = 0;
            end else if (waitData) begin
                if (dCnt == 0) begin
                    data_data_ok = 1; data_rdata = busRdata; waitData = 0;
                end else dCnt--;
            end else if (data_req) begin
                if (aCnt >= aokDly) begin
                    data_addr_ok = 1; aCnt = 0;
                    if (dokDly == 0) begin
                        data_data_ok = 1; data_rdata = busRdata;
                    end else begin
                        waitData = 1; dCnt = dokDly - 1;
                    end
                end else aCnt++;
            end
        end
    end

    // Monitor
    int stallCnt = 0;
    reqExp_t mr;
    cmpExp_t mc;
    always @(negedge clk) begin
        if (rst || !mem_en) stallCnt = 0;
        else if (stall_mem) stallCnt++;
        else if (mem_advance && !flush) begin
            if (cmpQ.size() == 0) chk("unexpectedDone", 1, 0);
            else begin
                mc = cmpQ.pop_front();
                chk("readdata", readdata, mc.rd);
                chk("stallCycles", stallCnt, mc.stall);
            end
            stallCnt = 0;
        end
        if (!rst && data_req && data_addr_ok) begin
            if (reqQ.size() == 0) chk("unexpectedReq", 1, 0);
            else begin
                mr = reqQ.pop_front();
                chk("data_wr", data_wr, mr.wr);
                chk("data_wstrb", data_wstrb, mr.strb);
                chk("data_addr", data_addr, mr.addr);
                chk("data_wdata", data_wdata, mr.wdata);
            end
        end
        if (!rst && data_req && !data_addr_ok) chk("reqWhileBusBusy", waitData, 0);
    end

    task automatic pushReq(input logic wr, input logic [3:0] strb, input logic [31:0] a, input logic [31:0] wd);
        reqExp_t r;
        r.wr = wr; r.strb = strb; r.addr = a; r.wdata = wd;
        reqQ.push_back(r);
    endtask

    // Called just after a posedge; returns just after the posedge ending the op.
    task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int aD, input int dD,
                         input logic [3:0] eStrb, input logic [31:0] eWd,
                         input logic [31:0] eRd, input int eStall, input int holdCyc);
        cmpExp_t c;
        int n;
        pushReq(w != 4'b0000, eStrb, {a[31:2], 2'b00}, eWd);
        c.rd = eRd; c.stall = eStall;
        cmpQ.push_back(c);
        aokDly = aD; dokDly = dD; busRdata = rd;
        mem_en = 1; wea = w; addrM = a; writedataM = wd; mem_advance = (holdCyc == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (stall_mem && n < 40);
        if (stall_mem) chk("stallTimeout", 1, 0);
        for (int i = 0; i < holdCyc; i++) begin
            chk("holdStall", stall_mem, 0);
            chk("holdReaddata", readdata, eRd);
            chk("holdNoReq", data_req, 0);
            @(posedge clk); #1;
            if (i == holdCyc - 1) mem_advance = 1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        mem_en = 0; wea = 0; writedataM = 0; mem_advance = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; mem_en = 0; wea = 0; addrM = 0; writedataM = 0; flush = 0; mem_advance = 1;
        aokDly = 0; dokDly = 1; busRdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstReaddata", readdata, 0);
        chk("rstStall", stall_mem, 0);
        chk("rstReq", data_req, 0);
        chk("rstWr", data_wr, 0);
        chk("rstWstrb", data_wstrb, 0);
        chk("rstAddr", data_addr, 0);
        chk("rstWdata", data_wdata, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        issue(4'b0000, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b0000, 32'h0,        32'hDEADBEEF, 3, 0);
        issue(4'b0001, 32'h103, 32'h000000AB, 32'h0,        0, 1, 4'b1000, 32'hAB000000, 32'hDEADBEEF, ST_STALL, 0);
        issue(4'b0000, 32'h202, 32'h0,        32'h12348765, 0, 1, 4'b0000, 32'h0,        32'h00001234, 3, 0);
        issue(4'b0011, 32'h202, 32'h00005566, 32'h0,        0, 1, 4'b1100, 32'h55660000, 32'h00001234, ST_STALL, 0);
        issue(4'b0000, 32'h101, 32'h0,        32'hA1B2C3D4, 2, 0, 4'b0000, 32'h0,        32'h00A1B2C3, 4, 3);
        issue(4'b0000, 32'h400, 32'h0,        32'hCAFEF00D, 0, 0, 4'b0000, 32'h0,        32'hCAFEF00D, 2, 0);

        // Flush while waiting in RESP: bus finishes, result dropped, no HOLD.
        pushReq(1'b0, 4'b0000, 32'h100, 32'h0);
        aokDly = 0; dokDly = 3; busRdata = 32'h11111111;
        mem_en = 1; wea = 0; addrM = 32'h100; writedataM = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1; mem_en = 0;
        @(negedge clk); chk("flushStall", stall_mem, 1);
        @(posedge clk); #1; flush = 0;
        n = 0;
        while (!data_data_ok && n < 20) begin
            @(negedge clk); n++;
            chk("flushStall", stall_mem, 1);
        end
        @(posedge clk); #1;
        chk("flushReaddataKept", readdata, 32'hCAFEF00D);
        // Next op directly after: a lingering HOLD would end it with zero stall.
        issue(4'b1111, 32'h104, 32'h01020304, 32'h0, 0, 1, 4'b1111, 32'h01020304, 32'hCAFEF00D, ST_STALL, 0);

        // Reset in RESP abandons the load.
        pushReq(1'b0, 4'b0000, 32'h500, 32'h0);
        aokDly = 0; dokDly = 3; busRdata = 32'h22222222;
        mem_en = 1; wea = 0; addrM = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; mem_en = 0;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("rstRespReq", data_req, 0);
        chk("rstRespReaddata", readdata, 0);
        chk("rstRespStall", stall_mem, 0);
        chk("rstRespAddr", data_addr, 0);
        @(posedge clk); #1;

        // Slow store followed by a load.
        issue(4'b1111, 32'h300, 32'h0BADF00D, 32'h0,      0, 4, 4'b1111, 32'h0BADF00D, 32'h0,      SW_SLOW, 0);
        issue(4'b0000, 32'h304, 32'h0,        32'h76543210, 0, 1, 4'b0000, 32'h0,     32'h76543210, LW_BEHIND, 0);

        repeat (6) @(posedge clk);
        chk("reqQEmpty", reqQ.size(), 0);
        chk("cmpQEmpty", cmpQ.size(), 0);
        $display("%0d/%0d checks passed", nChk - nFail, nChk);
        $finish;
    end

endmodule
